if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage RV32I pipeline. Owns the program counter, issues one fetch per cycle to a synchronous instruction memory (1-cycle read latency, always ready), and presents `{instr, pc}` to the ID stage with a valid/ready handshake. A one-entry hold buffer absorbs ID back-pressure, and redirects from the branch/jump logic flush wrong-path fetches.

## Interface
- `BOOT_ADDR`, default `32'h0000_0000`: reset and `PC_BOOT` target.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `fetch_enable_i  in  1`: starts fetching. Sampled only in `S_IDLE`.
- `pc_set_i  in  1`: redirect request.
- `pc_mux_sel_i  in  4`: redirect source, encoded as `PC_BOOT`, `PC_JUMP` or `PC_BRANCH`.
- `jump_target_i  in  32`: JAL/JALR target.
- `branch_target_i  in  32`: taken-branch target.
- `id_ready_i  in  1`: ID accepts the presented instruction this cycle.
- `instr_req_o  out  1`: memory read strobe.
- `instr_addr_o  out  32`: memory read address.
- `instr_rdata_i  in  32`: read data, valid the cycle after the request.
- `instr_valid_o  out  1`: `instr_o` / `pc_id_o` are valid.
- `instr_o  out  32`: instruction to ID.
- `pc_id_o  out  32`: PC of `instr_o`.

## Operation
- FSM `S_IDLE` → `S_RUN` when `fetch_enable_i=1`. `S_RUN` is left only by `rst`.
- `issue = S_RUN & !pc_set_i & (id_ready_i | !instr_valid_o)`.
  - `instr_req_o = issue`.
  - `instr_addr_o = pc_q`.
  - On issue, `pc_q <= pc_q + 4`.
- In-flight tracking:
  - `resp_valid_q <= issue`.
  - `resp_pc_q <= pc_q` when `issue`.
- Output select:
  - If `hold_valid_q`: present `hold_instr_q` and `hold_pc_q`.
  - Else: present `instr_rdata_i` and `resp_pc_q`, with valid = `resp_valid_q`.
- `instr_valid_o` is forced to 0 in any cycle where `pc_set_i=1`. This is a combinational kill.
- Hold capture: if `!hold_valid_q & resp_valid_q & !id_ready_i & !pc_set_i`, load the hold buffer with `instr_rdata_i` and `resp_pc_q`, and set `hold_valid_q`.
- Hold release: `hold_valid_q` clears when `id_ready_i=1` or `pc_set_i=1`.
- At most one in-flight response plus one held entry exist at any time. No instruction is dropped or duplicated except by a redirect.
- Redirect (`pc_set_i=1`):
  - `pc_q` loads `BOOT_ADDR`, `jump_target_i` or `branch_target_i` according to `pc_mux_sel_i`.
  - Any other encoding: `pc_q` holds, but the flush still occurs.
  - `resp_valid_q` and `hold_valid_q` clear. No issue this cycle.
  - A redirect in `S_IDLE` updates `pc_q` only.
- Width rule: loaded targets have bits [1:0] forced to `2'b00`. `pc_q + 4` wraps modulo 2^32 (`32'hFFFF_FFFC` → `32'h0000_0000`).

## Timing
- Reset values: state `S_IDLE`; `pc_q = BOOT_ADDR`; `resp_valid_q = 0`; `hold_valid_q = 0`; `resp_pc_q = BOOT_ADDR`; hold data regs 0.
- Outputs under reset: `instr_req_o = 0`, `instr_valid_o = 0`, `instr_addr_o = BOOT_ADDR`, `pc_id_o = BOOT_ADDR`.
- Startup: `fetch_enable_i` high in cycle E. First request in E+1. First valid instruction in E+2.
- Steady state: 1 instruction/cycle while `id_ready_i=1`.
- Stall release: when `id_ready_i` rises with the hold entry valid, the hold entry is consumed and a new issue happens in the same cycle. No bubble.
- Redirect in cycle R:
  - Target address issued in R+1.
  - Target instruction valid in R+2.
  - Penalty: 2 bubbles.
- Redirect and stall in the same cycle: the redirect wins. The hold entry is discarded.
- `rst` mid-operation: all state returns to reset values next cycle. A pending response is ignored.
- Combinational paths:
  - `pc_set_i` → `instr_valid_o`, `instr_req_o`.
  - `id_ready_i` → `instr_req_o`.
  - `instr_rdata_i` → `instr_o`.

## Structure
- Add to `core_pkg`:
  - `typedef enum logic [0:0] {S_IDLE, S_RUN} if_state_e`.
  - `parameter PC_INCR = 4`.
- Reuse the existing `PC_BOOT`, `PC_JUMP` and `PC_BRANCH` encodings. Do not redefine them.
- One sub-module: `if_hold_buffer`. It holds the one-entry data/pc register with its capture and release logic.
- PC register, next-PC mux and FSM stay in `if_stage`.

## Test plan
- Boot: `BOOT_ADDR = 32'h100`, `fetch_enable_i` high in cycle 2, `id_ready_i = 1`, memory returns addr^`32'hA5A5_0000`.
  - Requests at 3, 4, 5 with addresses `0x100`, `0x104`, `0x108`.
  - Valid outputs at 4, 5, 6 carrying the matching data and `pc_id_o`.
- Stall: drop `id_ready_i` for 3 cycles while `pc_id_o = 0x104`.
  - `0x104` is held stable and no requests are issued.
  - On release, the sequence continues `0x108`, `0x10C` with no gap and no duplicate.
- Jump: `pc_set_i = 1`, `pc_mux_sel_i = PC_JUMP`, `jump_target_i = 32'h203` in cycle R.
  - `instr_valid_o = 0` in R and R+1.
  - Request to `0x200` in R+1. Valid `pc_id_o = 0x200` in R+2.
- Redirect during stall: hold entry valid, then `PC_BRANCH` to `0x40`.
  - The held instruction never reaches ID.
  - Next valid `pc_id_o = 0x40`.
- Wrap and illegal select:
  - Jump to `0xFFFF_FFFC`: next fetch address `0x0`.
  - Redirect with `pc_mux_sel_i = 4'b1111`: outputs flushed, `pc_q` unchanged.
- Reset mid-run: assert `rst` for 1 cycle with a response in flight and the hold entry valid.
  - Next cycle: `instr_valid_o = 0`, `instr_req_o = 0`, `instr_addr_o = BOOT_ADDR`.
  - FSM in `S_IDLE` until `fetch_enable_i` is reasserted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: PC redirect source encodings and fetch-stage types.
package core_pkg;

  localparam logic [3:0] PC_BOOT   = 4'h0;
  localparam logic [3:0] PC_JUMP   = 4'h2;
  localparam logic [3:0] PC_BRANCH = 4'h3;

  typedef enum logic [0:0] {S_IDLE, S_RUN} if_state_e;

  parameter int unsigned PC_INCR = 4;

  // Redirect targets are always word aligned before they reach the PC.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry skid register that parks a fetched instruction while ID stalls.
module if_hold_buffer
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        resp_valid_i,
  input  logic        id_ready_i,
  input  logic        flush_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] pc_i,
  output logic        hold_valid_o,
  output logic [31:0] hold_instr_o,
  output logic [31:0] hold_pc_o
);

  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        capture;

  // Only a live response that ID refused, with no redirect pending, is parked.
  assign capture = !hold_valid_q && resp_valid_i && !id_ready_i && !flush_i;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (capture) begin
      hold_valid_d = 1'b1;
      hold_instr_d = rdata_i;
      hold_pc_d    = pc_i;
    end else if (id_ready_i || flush_i) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign hold_valid_o = hold_valid_q;
  assign hold_instr_o = hold_instr_q;
  assign hold_pc_o    = hold_pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, fetch FSM and ID handshake.
module if_stage
  import core_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable_i,
  input  logic        pc_set_i,
  input  logic [3:0]  pc_mux_sel_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_id_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q, resp_pc_d;

  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        present_valid;
  logic        issue;

  if_hold_buffer u_hold (
    .clk          (clk),
    .rst          (rst),
    .resp_valid_i (resp_valid_q),
    .id_ready_i   (id_ready_i),
    .flush_i      (pc_set_i),
    .rdata_i      (instr_rdata_i),
    .pc_i         (resp_pc_q),
    .hold_valid_o (hold_valid),
    .hold_instr_o (hold_instr),
    .hold_pc_o    (hold_pc)
  );

  assign present_valid = hold_valid || resp_valid_q;

  // A new fetch may only go out when the slot toward ID will be free next cycle.
  assign issue = (state_q == S_RUN) && !pc_set_i && (id_ready_i || !present_valid);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_valid_d = issue;
    resp_pc_d    = issue ? pc_q : resp_pc_q;
    if (state_q == S_IDLE && fetch_enable_i) begin
      state_d = S_RUN;
    end
    if (pc_set_i) begin
      unique case (pc_mux_sel_i)
        PC_BOOT:   pc_d = alignPc(BOOT_ADDR);
        PC_JUMP:   pc_d = alignPc(jump_target_i);
        PC_BRANCH: pc_d = alignPc(branch_target_i);
        default:   pc_d = pc_q;
      endcase
    end else if (issue) begin
      pc_d = pc_q + 32'(PC_INCR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= BOOT_ADDR;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= BOOT_ADDR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
    end
  end

  assign instr_req_o   = issue;
  assign instr_addr_o  = pc_q;
  assign instr_valid_o = present_valid && !pc_set_i;
  assign instr_o       = hold_valid ? hold_instr : instr_rdata_i;
  assign pc_id_o       = hold_valid ? hold_pc : resp_pc_q;

endmodule
